uart_tx_dev: RTL and testbench
==============================

# uart_tx_dev

Bridge-attached UART transmitter peripheral: a memory-mapped responder on the same CPU↔Bridge device port as the timers, occupying one device slot. The CPU writes bytes into a small TX FIFO. The block serialises them on `txd` as 8N1 frames at a programmable divisor. It raises `IRQ` to the CPU's hardware-interrupt vector when the FIFO has drained.

## Interface
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..16.
- `DIV_DEFAULT`, 16'd16: reset value of the DIV register, in clocks per bit.

Ports:
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `Addr`  in  30  word address (`Addr[31:2]` from bridge); only `Addr[3:2]` is decoded.
- `WE`  in  1  write enable for this device, from the bridge.
- `Din`  in  32  write data.
- `Dout`  out  32  read data; combinational from `Addr[3:2]` and registers.
- `IRQ`  out  1  level interrupt request.
- `txd`  out  1  serial output, registered, idle high.

## Operation
Register map, indexed by `Addr[3:2]`:
- 0 DATA
  - Write: push `Din[7:0]` into the FIFO.
  - Read: returns 0.
- 1 CTRL, R/W, bits [1:0]; [2] exists only with the parity feature.
  - [0] TXEN.
  - [1] IRQEN.
  - [2] ODD.
  - Any CTRL write clears OVF.
- 2 STATUS, read-only.
  - [0] BUSY (state ≠ IDLE).
  - [1] FULL.
  - [2] EMPTY.
  - [3] OVF, sticky.
  - [8:4] FIFO count.
- 3 DIV, R/W, bits [15:0].
  - A written value of 0 is stored as 1.
  - Upper bits read as 0.

FIFO behaviour:
- A push when FULL is dropped and sets OVF.
- FULL is evaluated before any pop in the same cycle, so a push into a full FIFO is dropped even if a pop occurs that cycle.

Transmit state machine (IDLE, START, DATA, STOP):
- IDLE → START when TXEN=1 and FIFO non-empty.
  - Pops the head into the shift register.
  - Latches DIV into `div_q`.
  - Clears the bit counter.
- START: `txd`=0 for `div_q` clocks → DATA.
- DATA: 8 bits, LSB first, each held `div_q` clocks → STOP.
- STOP: `txd`=1 for `div_q` clocks.
  - If TXEN=1 and FIFO non-empty, pop and go straight to START with no gap.
  - Otherwise go to IDLE.
- Clearing TXEN mid-frame: the current frame completes; no further pops.
- A DIV write takes effect at the next frame start.

Interrupt: `IRQ` = IRQEN & (state==IDLE) & EMPTY, decoded from registers only.

Reset values:
- Outputs: `txd`=1, `IRQ`=0.
- Registers: CTRL=0, DIV=DIV_DEFAULT, OVF=0.
- FIFO empty; state IDLE.
- Reset mid-frame aborts the frame: `txd`=1 from the next edge.

## Timing
- A DATA write is sampled at edge E0.
  - If the machine is IDLE with TXEN=1, the pop happens at E1.
  - `txd` falls right after E1.
- Frame = 10·`div_q` clocks; back-to-back frames are exactly contiguous.
- STATUS/IRQ reflect a push or pop from the edge that performs it.
- `Dout` is valid in the same cycle `Addr` is presented, with no wait states.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP, lasting `div_q` clocks; the frame becomes 11·`div_q`.
  - The parity bit is even parity of the data byte, inverted when CTRL[2] ODD=1.
  - CTRL is 3 bits wide.
- Undefined:
  - 8N1 only.
  - CTRL[2] is not implemented and reads 0.

## Test plan
- Reset, then read all registers → `txd`=1, `IRQ`=0, STATUS=0x004, DIV=DIV_DEFAULT, CTRL=0.
- DIV=4, CTRL=1, DATA=0xA5 → `txd` is low 4 clocks starting after the edge following the write. Data bits are 1,0,1,0,0,1,0,1 at 4 clocks each, then stop high 4 clocks. BUSY clears after 40 clocks.
- With TXEN=0, write 0x01..0x05 (FIFO_DEPTH=4) → STATUS count=4, FULL=1, OVF=1. Then CTRL=1 → four contiguous frames 0x01..0x04 (160 clocks at DIV=4); 0x05 is never sent. The CTRL write also clears OVF.
- CTRL=3 with FIFO empty → `IRQ`=1. Write DATA → `IRQ`=0 from the write edge. `IRQ` returns to 1 on the cycle IDLE is re-entered after the stop bit.
- `reset` asserted mid-DATA-bit → next cycle `txd`=1, STATUS=0x004, DIV=DIV_DEFAULT; no residual bits are sent afterwards.
- With `UART_TX_PARITY_EN`, DIV=2, send 0x07 with ODD=0, then ODD=1 → parity bit is 1, then 0. Each frame is 22 clocks.

Source files
------------

// File: rtl/uart_tx_dev.sv
// uart_tx_dev: bridge-attached UART transmitter with TX FIFO and IRQ.
// Optional macro: UART_TX_PARITY_EN adds a parity bit (frame 8E1/8O1).
//
// Ports:
//   clk   - system clock, all state on rising edge
//   reset - synchronous active-high reset
//   Addr  - word address [31:2]; only Addr[3:2] decoded
//   WE    - write enable from bridge
//   Din   - write data
//   Dout  - combinational read data
//   IRQ   - level interrupt: IRQEN & idle & FIFO empty
//   txd   - registered serial output, idle high
// Registers: 0 DATA, 1 CTRL, 2 STATUS, 3 DIV.

module uart_tx_dev #(
   parameter int          FIFO_DEPTH  = 4,
   parameter logic [15:0] DIV_DEFAULT = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   output logic        txd
);

   localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
   localparam int CW = 3;
`else
   localparam int CW = 2;
`endif

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP
   } state_t;
`endif

   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic [CW-1:0] r_ctrl;
   logic [15:0]   r_div;
   logic [15:0]   r_div_q;
   logic [15:0]   r_tick;
   logic          r_ovf;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic          r_txd;
`ifdef UART_TX_PARITY_EN
   logic          r_par;
`endif
   state_t        r_state;
   state_t        w_state_n;

   logic          w_full;
   logic          w_empty;
   logic          w_busy;
   logic          w_wr_data;
   logic          w_wr_ctrl;
   logic          w_wr_div;
   logic          w_push;
   logic          w_pop;
   logic          w_shift_en;
   logic          w_txd_n;
   logic          w_tick_end;
   logic          w_can_start;
   logic [4:0]    w_cnt5;
   logic          w_unused;

   assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
   assign w_empty   = (r_cnt == '0);
   assign w_busy    = (r_state != S_IDLE);
   assign w_wr_data = WE & (Addr[3:2] == 2'd0);
   assign w_wr_ctrl = WE & (Addr[3:2] == 2'd1);
   assign w_wr_div  = WE & (Addr[3:2] == 2'd3);
   // FULL is judged before any same-cycle pop
   assign w_push    = w_wr_data & ~w_full;
   assign w_tick_end  = (r_tick == r_div_q - 16'd1);
   assign w_can_start = r_ctrl[0] & ~w_empty;
   assign w_cnt5    = 5'(r_cnt);
   assign w_unused  = &{1'b0, Addr[31:4], Din[31:16]};

   // Transmit FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_n;
   end

   // Next state; w_txd_n is the line level of the bit being entered
   always_comb begin
      w_state_n  = r_state;
      w_pop      = 1'b0;
      w_shift_en = 1'b0;
      w_txd_n    = r_txd;
      unique case (r_state)
         S_IDLE: begin
            if (w_can_start) begin
               w_state_n = S_START;
               w_pop     = 1'b1;
               w_txd_n   = 1'b0;
            end
         end
         S_START: begin
            if (w_tick_end) begin
               w_state_n = S_DATA;
               w_txd_n   = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_tick_end) begin
               if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_n = S_PARITY;
                  w_txd_n   = r_par;
`else
                  w_state_n = S_STOP;
                  w_txd_n   = 1'b1;
`endif
               end else begin
                  w_shift_en = 1'b1;
                  w_txd_n    = r_shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         S_PARITY: begin
            if (w_tick_end) begin
               w_state_n = S_STOP;
               w_txd_n   = 1'b1;
            end
         end
`endif
         S_STOP: begin
            if (w_tick_end) begin
               if (w_can_start) begin
                  w_state_n = S_START;
                  w_pop     = 1'b1;
                  w_txd_n   = 1'b0;
               end else begin
                  w_state_n = S_IDLE;
                  w_txd_n   = 1'b1;
               end
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_txd_n   = 1'b1;
         end
      endcase
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= Din[7:0];
   end

   // FIFO pointers, count, sticky overflow
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else begin
         if (w_push) r_wp <= r_wp + 1'b1;
         if (w_pop)  r_rp <= r_rp + 1'b1;
         r_cnt <= r_cnt + (AW+1)'(w_push)
                        - (AW+1)'(w_pop);
         if (w_wr_ctrl)
            r_ovf <= 1'b0;
         else if (w_wr_data & w_full)
            r_ovf <= 1'b1;
      end
   end

   // CTRL and DIV registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ctrl <= '0;
         r_div  <= DIV_DEFAULT;
      end else begin
         if (w_wr_ctrl) r_ctrl <= Din[CW-1:0];
         if (w_wr_div)
            r_div <= (Din[15:0] == 16'd0) ?
                     16'd1 : Din[15:0];
      end
   end

   // Bit timing, shifter and line driver
   always_ff @(posedge clk) begin
      if (reset) begin
         r_txd   <= 1'b1;
         r_div_q <= 16'd1;
         r_tick  <= '0;
         r_bit   <= '0;
         r_shift <= '0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         r_txd  <= w_txd_n;
         r_tick <= (r_state == S_IDLE || w_tick_end) ?
                   16'd0 : r_tick + 16'd1;
         if (w_pop) begin
            r_shift <= r_mem[r_rp];
            r_div_q <= r_div;
            r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
            r_par   <= (^r_mem[r_rp]) ^ r_ctrl[2];
`endif
         end else if (w_shift_en) begin
            r_shift <= {1'b0, r_shift[7:1]};
            r_bit   <= r_bit + 3'd1;
         end
      end
   end

   // Register read mux
   always_comb begin
      Dout = '0;
      unique case (Addr[3:2])
         2'd0: Dout = '0;
         2'd1: Dout[CW-1:0] = r_ctrl;
         2'd2: Dout[8:0] = {w_cnt5, r_ovf, w_empty,
                            w_full, w_busy};
         2'd3: Dout[15:0] = r_div;
         default: Dout = '0;
      endcase
   end

   assign IRQ = r_ctrl[1] & ~w_busy & w_empty;
   assign txd = r_txd;

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev: self-checking bench for uart_tx_dev.
// Expected line waveforms come from a frame-level model.

module tb_uart_tx_dev;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:2] Addr = '0;
   logic        WE = 1'b0;
   logic [31:0] Din = '0;
   logic [31:0] Dout;
   logic        IRQ;
   logic        txd;

   int checks = 0;
   int failures = 0;

`ifdef UART_TX_PARITY_EN
   localparam int FLEN = 11;
`else
   localparam int FLEN = 10;
`endif

   typedef logic bq_t[$];
   typedef logic [7:0] byq_t[$];

   uart_tx_dev #(
      .FIFO_DEPTH (4),
      .DIV_DEFAULT(16'd16)
   ) dut (
      .clk (clk),
      .reset(reset),
      .Addr(Addr),
      .WE  (WE),
      .Din (Din),
      .Dout(Dout),
      .IRQ (IRQ),
      .txd (txd)
   );

   always #5 clk = ~clk;

   // Line level per clock for a contiguous run of frames
   function automatic bq_t wave(input byq_t bs,
                                input int div,
                                input logic odd);
      bq_t w;
      logic b;
      w = {};
      foreach (bs[i]) begin
         for (int j = 0; j < FLEN; j++) begin
            if (j == 0)
               b = 1'b0;
            else if (j <= 8)
               b = bs[i][j-1];
            else if (FLEN == 11 && j == 9)
               b = (^bs[i]) ^ odd;
            else
               b = 1'b1;
            for (int k = 0; k < div; k++)
               w.push_back(b);
         end
      end
      return w;
   endfunction

   task automatic wr(input int a, input logic [31:0] d);
      @(posedge clk); #1;
      Addr = '0;
      Addr[3:2] = 2'(a);
      Din = d;
      WE = 1'b1;
      @(posedge clk); #1;
      WE = 1'b0;
   endtask

   task automatic rd(input int a, output logic [31:0] d);
      Addr = '0;
      Addr[3:2] = 2'(a);
      #1;
      d = Dout;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (txd !== 1'b1) begin
         failures++;
         $display("FAIL reset_txd got=%b exp=1", txd);
      end
      checks++;
      if (IRQ !== 1'b0) begin
         failures++;
         $display("FAIL reset_irq got=%b exp=0", IRQ);
      end
      rd(2, d);
      checks++;
      if (d !== 32'h4) begin
         failures++;
         $display("FAIL reset_status got=%h exp=4", d);
      end
      rd(3, d);
      checks++;
      if (d !== 32'd16) begin
         failures++;
         $display("FAIL reset_div got=%h exp=10", d);
      end
      rd(1, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL reset_ctrl got=%h exp=0", d);
      end
      rd(0, d);
      checks++;
      if (d !== 32'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=0", d);
      end
   endtask

   task automatic test_regs;
      logic [31:0] d;
      wr(3, 32'h0);
      rd(3, d);
      checks++;
      if (d !== 32'd1) begin
         failures++;
         $display("FAIL div_zero got=%h exp=1", d);
      end
      wr(3, 32'hFFFF_1234);
      rd(3, d);
      checks++;
      if (d !== 32'h1234) begin
         failures++;
         $display("FAIL div_upper got=%h exp=1234", d);
      end
      wr(1, 32'hFF);
      rd(1, d);
      checks++;
      if (d !== ((FLEN == 11) ? 32'h7 : 32'h3)) begin
         failures++;
         $display("FAIL ctrl_width got=%h", d);
      end
      wr(1, 32'h0);
      wr(3, 32'd4);
   endtask

   task automatic test_single;
      byq_t q;
      bq_t e;
      logic [31:0] d;
      int bad;
      int first;
      q = {};
      q.push_back(8'hA5);
      e = wave(q, 4, 1'b0);
      wr(3, 32'd4);
      wr(1, 32'h1);
      wr(0, 32'hA5);
      bad = 0;
      first = -1;
      foreach (e[k]) begin
         @(posedge clk); #1;
         if (txd !== e[k]) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL single_wave bad=%0d first=%0d exp=0",
                  bad, first);
      end
      rd(2, d);
      checks++;
      if (d[0] !== 1'b1) begin
         failures++;
         $display("FAIL single_busy_end got=%b exp=1", d[0]);
      end
      @(posedge clk); #1;
      rd(2, d);
      checks++;
      if (d !== 32'h4) begin
         failures++;
         $display("FAIL single_idle got=%h exp=4", d);
      end
   endtask

   task automatic test_overflow;
      byq_t q;
      bq_t e;
      logic [31:0] d;
      int bad;
      wr(3, 32'd4);
      wr(1, 32'h0);
      for (int i = 1; i <= 5; i++)
         wr(0, 32'(i));
      rd(2, d);
      checks++;
      if (d !== 32'h4A) begin
         failures++;
         $display("FAIL ovf_status got=%h exp=4a", d);
      end
      q = {};
      for (int i = 1; i <= 4; i++)
         q.push_back(8'(i));
      e = wave(q, 4, 1'b0);
      wr(1, 32'h1);
      rd(2, d);
      checks++;
      if (d !== 32'h42) begin
         failures++;
         $display("FAIL ovf_clear got=%h exp=42", d);
      end
      bad = 0;
      foreach (e[k]) begin
         @(posedge clk); #1;
         if (txd !== e[k]) bad++;
      end
      checks++;
      if (bad != 0 || e.size() != 160) begin
         failures++;
         $display("FAIL b2b_wave bad=%0d exp=0", bad);
      end
      bad = 0;
      repeat (60) begin
         @(posedge clk); #1;
         if (txd !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL fifth_sent bad=%0d exp=0", bad);
      end
      rd(2, d);
      checks++;
      if (d !== 32'h4) begin
         failures++;
         $display("FAIL b2b_status got=%h exp=4", d);
      end
   endtask

   task automatic test_irq;
      int bad;
      wr(3, 32'd4);
      wr(1, 32'h3);
      checks++;
      if (IRQ !== 1'b1) begin
         failures++;
         $display("FAIL irq_idle got=%b exp=1", IRQ);
      end
      wr(0, 32'h3C);
      checks++;
      if (IRQ !== 1'b0) begin
         failures++;
         $display("FAIL irq_push got=%b exp=0", IRQ);
      end
      bad = 0;
      repeat (FLEN * 4) begin
         @(posedge clk); #1;
         if (IRQ !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL irq_frame bad=%0d exp=0", bad);
      end
      @(posedge clk); #1;
      checks++;
      if (IRQ !== 1'b1) begin
         failures++;
         $display("FAIL irq_return got=%b exp=1", IRQ);
      end
      wr(1, 32'h1);
   endtask

   task automatic test_random;
      byq_t q;
      bq_t e;
      logic [31:0] d;
      int div;
      int nb;
      int bad;
      logic odd;
      for (int n = 0; n < 6; n++) begin
         div = int'($urandom_range(1, 6));
         nb = int'($urandom_range(1, 3));
         odd = 1'($urandom_range(0, 1));
         wr(1, 32'h0);
         wr(3, 32'(div));
         q = {};
         for (int i = 0; i < nb; i++) begin
            q.push_back(8'($urandom));
            wr(0, 32'(q[i]));
         end
         e = wave(q, div, odd);
         wr(1, {29'd0, odd, 2'b01});
         bad = 0;
         foreach (e[k]) begin
            @(posedge clk); #1;
            if (txd !== e[k]) bad++;
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL rand_wave n=%0d div=%0d bad=%0d exp=0",
                     n, div, bad);
         end
         @(posedge clk); #1;
         rd(2, d);
         checks++;
         if (d !== 32'h4) begin
            failures++;
            $display("FAIL rand_idle n=%0d got=%h exp=4", n, d);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      int bad;
      wr(3, 32'd4);
      wr(1, 32'h1);
      wr(0, 32'h00);
      wr(0, 32'h00);
      repeat (7) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if (txd !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_txd got=%b exp=1", txd);
      end
      rd(2, d);
      checks++;
      if (d !== 32'h4) begin
         failures++;
         $display("FAIL rst_mid_status got=%h exp=4", d);
      end
      rd(3, d);
      checks++;
      if (d !== 32'd16) begin
         failures++;
         $display("FAIL rst_mid_div got=%h exp=10", d);
      end
      bad = 0;
      repeat (80) begin
         @(posedge clk); #1;
         if (txd !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL rst_mid_residual bad=%0d exp=0", bad);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity;
      byq_t q;
      bq_t e;
      logic pb;
      int bad;
      q = {};
      q.push_back(8'h07);
      for (int m = 0; m < 2; m++) begin
         e = wave(q, 2, 1'(m));
         wr(1, 32'h0);
         wr(3, 32'd2);
         wr(1, (m == 1) ? 32'h5 : 32'h1);
         wr(0, 32'h07);
         bad = 0;
         pb = 1'bx;
         foreach (e[k]) begin
            @(posedge clk); #1;
            if (k == 18) pb = txd;
            if (txd !== e[k]) bad++;
         end
         checks++;
         if (bad != 0 || e.size() != 22) begin
            failures++;
            $display("FAIL par_wave m=%0d bad=%0d exp=0", m, bad);
         end
         checks++;
         if (pb !== ((m == 1) ? 1'b0 : 1'b1)) begin
            failures++;
            $display("FAIL par_bit m=%0d got=%b", m, pb);
         end
         repeat (3) @(posedge clk);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_regs();
      test_single();
      test_overflow();
      test_irq();
      test_random();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
